// File: rtl/microc_stk.sv
// Microcontroller datapath: PC, decode, register file, 8-op ALU, zero flag,
// skip and a hardware return-address stack. Optional carry flag: MICROC_CARRY_EN.
module microc_stk #(
    parameter int DW     = 8,
    parameter int PCW    = 10,
    parameter int RAW    = 4,
    parameter int SDEPTH = 4,
    localparam int IW    = 6 + 3 * RAW,
    localparam int SPW   = $clog2(SDEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IW-1:0]  instr,
    input  logic           s_inc,
    input  logic           s_skip,
    input  logic           s_inm,
    input  logic           we3,
    input  logic [2:0]     op,
    input  logic           push,
    input  logic           pop,
    output logic [PCW-1:0] iaddr,
    output logic [5:0]     opcode,
    output logic           z,
    output logic [SPW-1:0] sp,
    output logic           stk_err
`ifdef MICROC_CARRY_EN
    ,
    output logic           c
`endif
);

    localparam int NREG = 2 ** RAW;
    localparam int IDXW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    logic [RAW-1:0] ra1, ra2, wa;
    logic [DW-1:0]  imm;
    logic [PCW-1:0] target;

    logic [DW-1:0]  rf_q [NREG];
    logic [DW-1:0]  a_val, b_val, alu_y, wd;

    logic [PCW-1:0] pc_q, pc_d, pc_plus1;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic           z_q, z_d;
    logic           push_en;
    logic [PCW-1:0] stk_q [SDEPTH];
    logic [PCW-1:0] stk_top;

    assign ra1    = instr[3*RAW-1:2*RAW];
    assign ra2    = instr[2*RAW-1:RAW];
    assign wa     = instr[RAW-1:0];
    assign imm    = instr[RAW+DW-1:RAW];
    assign target = instr[PCW-1:0];
    assign opcode = instr[IW-1:IW-6];

    // R0 is hard-wired to zero on the read side; writes to it never land.
    assign a_val = (ra1 == '0) ? '0 : rf_q[ra1];
    assign b_val = (ra2 == '0) ? '0 : rf_q[ra2];

    always_comb begin
        alu_y = a_val;
        case (op)
            3'b000:  alu_y = a_val;
            3'b001:  alu_y = ~a_val;
            3'b010:  alu_y = a_val + b_val;
            3'b011:  alu_y = a_val - b_val;
            3'b100:  alu_y = a_val & b_val;
            3'b101:  alu_y = a_val | b_val;
            3'b110:  alu_y = '0 - a_val;
            default: alu_y = '0 - b_val;
        endcase
    end

    assign wd       = s_inm ? imm : alu_y;
    assign z_d      = s_inm ? z_q : (alu_y == '0);
    assign pc_plus1 = pc_q + PCW'(1);
    assign stk_top  = stk_q[IDXW'(sp_q - SPW'(1))];

    // Pop outranks everything, including a simultaneous push.
    always_comb begin
        pc_d    = pc_plus1;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (pop) begin
            if (sp_q != '0) begin
                pc_d = stk_top;
                sp_d = sp_q - SPW'(1);
            end else begin
                err_d = 1'b1;
            end
            if (push) begin
                err_d = 1'b1;
            end
        end else if (!s_inc) begin
            pc_d = target;
            if (push) begin
                if (sp_q < SPW'(SDEPTH)) begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SPW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (s_skip) begin
            pc_d = pc_q + PCW'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
            z_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
            z_q   <= z_d;
            if (we3 && (wa != '0)) begin
                rf_q[wa] <= wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_en) begin
            stk_q[IDXW'(sp_q)] <= pc_plus1;
        end
    end

`ifdef MICROC_CARRY_EN
    logic          c_q, c_d;
    logic [DW:0]   sum_ext;

    assign sum_ext = {1'b0, a_val} + {1'b0, b_val};

    always_comb begin
        c_d = c_q;
        if (!s_inm && (op == 3'b010)) begin
            c_d = sum_ext[DW];
        end else if (!s_inm && (op == 3'b011)) begin
            c_d = (a_val < b_val);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            c_q <= 1'b0;
        end else begin
            c_q <= c_d;
        end
    end

    assign c = c_q;
`endif

    assign iaddr   = pc_q;
    assign z       = z_q;
    assign sp      = sp_q;
    assign stk_err = err_q;

endmodule

// File: tb/tb_microc_stk.sv
// Scoreboard bench for microc_stk: stimulus queues hand-computed post-edge state,
// a monitor pops and compares one entry after every clock edge.
module tb_microc_stk;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [17:0] instr = '0;
    logic        sInc = 1'b1, sSkip = 1'b0, sInm = 1'b1, we3 = 1'b0;
    logic [2:0]  op = '0;
    logic        push = 1'b0, pop = 1'b0;
    logic [9:0]  iaddr;
    logic [5:0]  opcode;
    logic        z;
    logic [2:0]  sp;
    logic        stkErr;
    logic        c;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        string      name;
        logic [9:0] pc;
        logic [2:0] sp;
        logic       err;
        logic       z;
        logic       c;
        logic [5:0] opc;
    } exp_t;

    exp_t sbQ[$];

    // Hand-maintained expectations for state not named in each call.
    logic [2:0] gSp = 0;
    logic       gErr = 0, gZ = 0, gC = 0;

    microc_stk dut (
        .clk(clk), .reset(resetN), .instr(instr),
        .s_inc(sInc), .s_skip(sSkip), .s_inm(sInm), .we3(we3), .op(op),
        .push(push), .pop(pop),
        .iaddr(iaddr), .opcode(opcode), .z(z), .sp(sp), .stk_err(stkErr)
`ifdef MICROC_CARRY_EN
        , .c(c)
`endif
    );

`ifndef MICROC_CARRY_EN
    assign c = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput(e.name, "iaddr",   32'(iaddr),  32'(e.pc));
                checkOutput(e.name, "sp",      32'(sp),     32'(e.sp));
                checkOutput(e.name, "stk_err", 32'(stkErr), 32'(e.err));
                checkOutput(e.name, "z",       32'(z),      32'(e.z));
                checkOutput(e.name, "opcode",  32'(opcode), 32'(e.opc));
`ifdef MICROC_CARRY_EN
                checkOutput(e.name, "c",       32'(c),      32'(e.c));
`endif
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [17:0] ins,
                                 input logic rstN, input logic inc, input logic skip,
                                 input logic inm, input logic we, input logic [2:0] o,
                                 input logic ps, input logic pp,
                                 input logic [9:0] ePc, input logic eZ);
        exp_t e;
        @(negedge clk);
        instr = ins; resetN = rstN; sInc = inc; sSkip = skip; sInm = inm;
        we3 = we; op = o; push = ps; pop = pp;
        e.name = name; e.pc = ePc; e.sp = gSp; e.err = gErr;
        e.z = eZ; e.c = gC; e.opc = ins[17:12];
        sbQ.push_back(e);
        gZ = eZ;
    endtask

    task automatic li(input string name, input logic [7:0] imm, input logic [3:0] wa,
                      input logic [9:0] ePc);
        applyStimulus(name, {6'h21, imm, wa}, 1, 1, 0, 1, 1, 3'b000, 0, 0, ePc, gZ);
    endtask

    task automatic alu(input string name, input logic [2:0] o, input logic [3:0] ra1,
                       input logic [3:0] ra2, input logic [3:0] wa, input logic we,
                       input logic [9:0] ePc, input logic eZ);
        applyStimulus(name, {6'h02, ra1, ra2, wa}, 1, 1, 0, 0, we, o, 0, 0, ePc, eZ);
    endtask

    task automatic jmp(input string name, input logic [9:0] tgt, input logic ps,
                       input logic pp, input logic [9:0] ePc);
        applyStimulus(name, {6'h03, 2'b00, tgt}, 1, 0, 0, 1, 0, 3'b000, ps, pp, ePc, gZ);
    endtask

    task automatic step(input string name, input logic skip, input logic ps,
                        input logic pp, input logic [9:0] ePc);
        applyStimulus(name, {6'h04, 12'h000}, 1, 1, skip, 1, 0, 3'b000, ps, pp, ePc, gZ);
    endtask

    // Reset with a call and a register write pending, both of which must be discarded.
    task automatic doReset(input string name);
        gSp = 0; gErr = 0; gC = 0;
        applyStimulus(name, {6'h05, 12'h321}, 0, 0, 0, 1, 1, 3'b000, 1, 0, 10'd0, 1'b0);
    endtask

    initial begin
        doReset("reset0");
        doReset("reset1");

        li("li5_r1", 8'd5, 4'd1, 10'd1);
        li("li3_r2", 8'd3, 4'd2, 10'd2);
        alu("sub_r1_r2_r3", 3'b011, 4'd1, 4'd2, 4'd3, 1, 10'd3, 0);
        alu("sub_r1_r1_r4", 3'b011, 4'd1, 4'd1, 4'd4, 1, 10'd4, 1);
        li("li2_r5_zhold", 8'd2, 4'd5, 10'd5);
        alu("r3_eq_2", 3'b011, 4'd3, 4'd5, 4'd0, 0, 10'd6, 1);
        alu("sub_nowrite", 3'b011, 4'd1, 4'd2, 4'd0, 0, 10'd7, 0);
        li("li9_r0", 8'd9, 4'd0, 10'd8);
        alu("r0_still_0", 3'b000, 4'd0, 4'd0, 4'd0, 0, 10'd9, 1);
        alu("not_r0", 3'b001, 4'd0, 4'd0, 4'd0, 0, 10'd10, 0);
        alu("and_5_3", 3'b100, 4'd1, 4'd2, 4'd0, 0, 10'd11, 0);
        alu("and_5_0", 3'b100, 4'd1, 4'd6, 4'd0, 0, 10'd12, 1);
        alu("add_3_3", 3'b010, 4'd2, 4'd2, 4'd0, 0, 10'd13, 0);
        alu("neg_r0", 3'b110, 4'd0, 4'd0, 4'd0, 0, 10'd14, 1);
        alu("negb_5", 3'b111, 4'd0, 4'd1, 4'd0, 0, 10'd15, 0);
        alu("or_0_2", 3'b101, 4'd0, 4'd5, 4'd0, 0, 10'd16, 0);
        alu("or_0_0", 3'b101, 4'd0, 4'd0, 4'd0, 0, 10'd17, 1);

        jmp("jump7", 10'd7, 0, 0, 10'd7);
        step("skip", 1, 0, 0, 10'd9);
        jmp("jump3ff", 10'h3FF, 0, 0, 10'h3FF);
        step("wrap", 0, 0, 0, 10'd0);

        jmp("jump4", 10'd4, 0, 0, 10'd4);
        gSp = 1; jmp("call20", 10'd20, 1, 0, 10'd20);
        gSp = 0; step("ret", 0, 0, 1, 10'd5);

        gSp = 1; jmp("call100", 10'd100, 1, 0, 10'd100);
        gSp = 2; jmp("call200", 10'd200, 1, 0, 10'd200);
        gSp = 3; jmp("call300", 10'd300, 1, 0, 10'd300);
        gSp = 4; jmp("call400", 10'd400, 1, 0, 10'd400);
        gErr = 1; jmp("call500_ovf", 10'd500, 1, 0, 10'd500);
        gSp = 3; step("pop301", 0, 0, 1, 10'd301);
        gSp = 2; step("pop201", 0, 0, 1, 10'd201);
        gSp = 1; step("pop101", 0, 0, 1, 10'd101);
        gSp = 0; step("pop6", 0, 0, 1, 10'd6);
        step("pop_unf", 0, 0, 1, 10'd7);

        doReset("reset_mid");
        alu("r1_cleared", 3'b000, 4'd1, 4'd0, 4'd0, 0, 10'd1, 1);
        alu("not_r0_b", 3'b001, 4'd0, 4'd0, 4'd0, 0, 10'd2, 0);
        alu("r5_cleared", 3'b000, 4'd5, 4'd0, 4'd0, 0, 10'd3, 1);
        step("push_inc_ign", 0, 1, 0, 10'd4);
        gSp = 1; jmp("call50", 10'd50, 1, 0, 10'd50);
        gSp = 0; gErr = 1; jmp("push_pop", 10'd90, 1, 1, 10'd5);

        doReset("reset2");
        gErr = 1; step("unf_after_rst", 0, 0, 1, 10'd1);
        step("unf_sticky", 0, 0, 1, 10'd2);

        li("liff_r1", 8'hFF, 4'd1, 10'd3);
        li("li1_r2", 8'h01, 4'd2, 10'd4);
        gC = 1; alu("add_ff_1", 3'b010, 4'd1, 4'd2, 4'd3, 1, 10'd5, 1);
        li("li2_r3", 8'h02, 4'd3, 10'd6);
        alu("sub_1_2", 3'b011, 4'd2, 4'd3, 4'd4, 1, 10'd7, 0);
        alu("and_holds_c", 3'b100, 4'd1, 4'd2, 4'd0, 0, 10'd8, 0);
        gC = 0; alu("add_1_1", 3'b010, 4'd2, 4'd2, 4'd0, 0, 10'd9, 0);

        @(negedge clk);
        resetN = 1'b1; sInc = 1'b1; sSkip = 1'b0; sInm = 1'b1; we3 = 1'b0;
        push = 1'b0; pop = 1'b0;
        for (int i = 0; i < 5 && sbQ.size() > 0; i++) @(posedge clk);
        #2;
        if (sbQ.size() > 0) begin
            nMismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
